// File: rtl/cfu_pkg.sv
// cfu_pkg: shared types and constants for the CFU issue/writeback controller.
package cfu_pkg;

  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;
  localparam int XLEN     = 32;
  localparam int RD_W     = 5;

  localparam int              TIMEOUT_CYCLES_DEF = 1024;
  localparam logic [XLEN-1:0] ERR_DATA_DEF       = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } state_e;

  // Instruction fields latched at accept and held for the CFU.
  typedef struct packed {
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic [RD_W-1:0]     rd;
  } cfu_req_t;

endpackage

// File: rtl/cfu_timeout_ctr.sv
// cfu_timeout_ctr: saturating cycle counter that flags a hung CFU.
// expire_o rises during the TIMEOUT_CYCLES-th enabled cycle after a clear.
module cfu_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == LIMIT);

  // Clear wins over enable; hold at the limit instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (en_i && !expire_o) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cfu_ctrl.sv
// cfu_ctrl: issue/writeback controller between execute and the CFU.
// Optional hang timeout built only when CFU_TIMEOUT_EN is defined (config.vh).
module cfu_ctrl
  import cfu_pkg::*;
#(
  parameter int              TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [XLEN-1:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic [FUNCT3_W-1:0] funct3_i,
  input  logic [FUNCT7_W-1:0] funct7_i,
  input  logic [XLEN-1:0]     src1_i,
  input  logic [XLEN-1:0]     src2_i,
  input  logic [RD_W-1:0]     rd_i,
  output logic                cfu_en_o,
  output logic [FUNCT3_W-1:0] cfu_funct3_o,
  output logic [FUNCT7_W-1:0] cfu_funct7_o,
  output logic [XLEN-1:0]     cfu_src1_o,
  output logic [XLEN-1:0]     cfu_src2_o,
  input  logic                cfu_stall_i,
  input  logic [XLEN-1:0]     cfu_rslt_i,
  output logic                stall_o,
  output logic                wb_valid_o,
  output logic [RD_W-1:0]     wb_rd_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic                err_o
);

  state_e          state_q, state_d;
  cfu_req_t        req_q, req_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            tmo_expire;
  logic            tmo_abort;

`ifdef CFU_TIMEOUT_EN
  logic err_q;
  logic tmo_run;

  assign tmo_run = (state_q == WAIT) || (state_q == DRAIN);

  cfu_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (!tmo_run),
    .en_i    (tmo_run),
    .expire_o(tmo_expire)
  );

  // err_q is set on the abort transition, so it is high exactly in that DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= tmo_abort;
  end

  assign err_o = err_q;
`else
  logic unused_cfg;

  assign tmo_expire = 1'b0;
  assign err_o      = 1'b0;
  assign unused_cfg = ^{ERR_DATA, TIMEOUT_CYCLES[0]};
`endif

  // A real result arriving in the expiry cycle still wins over the abort.
  assign tmo_abort = (state_q == WAIT) && cfu_stall_i && !flush_i && tmo_expire;

  // Next-state, latch updates and the combinational pipeline stall.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    stall_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Reset gating keeps stall low while rst_ni is asserted.
        stall_o = rst_ni & valid_i & ~flush_i;
        if (valid_i && !flush_i) begin
          req_d   = '{funct3: funct3_i, funct7: funct7_i,
                      src1: src1_i, src2: src2_i, rd: rd_i};
          state_d = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        stall_o = 1'b1;
        if (flush_i) begin
          // The CFU cannot be aborted, so a busy op must finish in DRAIN.
          state_d = cfu_stall_i ? DRAIN : IDLE;
        end else if (!cfu_stall_i) begin
          wb_data_d = cfu_rslt_i;
          wb_rd_d   = req_q.rd;
          state_d   = DONE;
        end else if (tmo_abort) begin
          wb_data_d = ERR_DATA;
          wb_rd_d   = req_q.rd;
          state_d   = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        stall_o = 1'b1;
        if (!cfu_stall_i || tmo_expire) state_d = IDLE;
      end
      DONE: begin
        // Pipeline advances here; a new valid_i is taken in the next IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign cfu_en_o     = (state_q == ISSUE) || (state_q == WAIT) || (state_q == DRAIN);
  assign cfu_funct3_o = req_q.funct3;
  assign cfu_funct7_o = req_q.funct7;
  assign cfu_src1_o   = req_q.src1;
  assign cfu_src2_o   = req_q.src2;
  assign wb_valid_o   = (state_q == DONE) && (wb_rd_q != '0);
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;

endmodule

// File: tb/tb_cfu_ctrl.sv
// tb_cfu_ctrl: directed self-checking bench with a writeback scoreboard.
module tb_cfu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, flush_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] src1_i, src2_i;
  logic [4:0]  rd_i;
  logic        cfu_en_o;
  logic [2:0]  cfu_funct3_o;
  logic [6:0]  cfu_funct7_o;
  logic [31:0] cfu_src1_o, cfu_src2_o;
  logic        cfu_stall_i;
  logic [31:0] cfu_rslt_i;
  logic        stall_o, wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  wb_cnt   = 0;

  cfu_ctrl #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .flush_i     (flush_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .rd_i        (rd_i),
    .cfu_en_o    (cfu_en_o),
    .cfu_funct3_o(cfu_funct3_o),
    .cfu_funct7_o(cfu_funct7_o),
    .cfu_src1_o  (cfu_src1_o),
    .cfu_src2_o  (cfu_src2_o),
    .cfu_stall_i (cfu_stall_i),
    .cfu_rslt_i  (cfu_rslt_i),
    .stall_o     (stall_o),
    .wb_valid_o  (wb_valid_o),
    .wb_rd_o     (wb_rd_o),
    .wb_data_o   (wb_data_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, pop the scoreboard on writeback,
  // then advance past the next rising edge.
  task automatic tick(input logic es, input logic ee, input logic ewb, input logic eerr);
    wb_t e;
    @(negedge clk_i);
    chk("stall_o",    32'(stall_o),    32'(es));
    chk("cfu_en_o",   32'(cfu_en_o),   32'(ee));
    chk("wb_valid_o", 32'(wb_valid_o), 32'(ewb));
    chk("err_o",      32'(err_o),      32'(eerr));
    if (wb_valid_o) begin
      wb_cnt++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(wb_valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_rd_o",   32'(wb_rd_o), 32'(e.rd));
        chk("wb_data_o", wb_data_o,    e.data);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_ops(input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] s1, input logic [31:0] s2);
    chk("cfu_funct3_o", 32'(cfu_funct3_o), 32'(f3));
    chk("cfu_funct7_o", 32'(cfu_funct7_o), 32'(f7));
    chk("cfu_src1_o",   cfu_src1_o,        s1);
    chk("cfu_src2_o",   cfu_src2_o,        s2);
  endtask

  task automatic drive(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [4:0] rd);
    valid_i  = 1'b1;
    funct3_i = f3;
    funct7_i = f7;
    src1_i   = s1;
    src2_i   = s2;
    rd_i     = rd;
  endtask

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; funct7_i = '0; src1_i = '0; src2_i = '0; rd_i = '0;
    cfu_stall_i = 1'b0; cfu_rslt_i = '0;

    // Reset state
    #3;
    chk("rst_cfu_en",   32'(cfu_en_o),   32'd0);
    chk("rst_stall",    32'(stall_o),    32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_err",      32'(err_o),      32'd0);
    chk("rst_wb_data",  wb_data_o,       32'd0);
    chk("rst_wb_rd",    32'(wb_rd_o),    32'd0);
    chk_ops(3'd0, 7'd0, 32'd0, 32'd0);
    #9 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single-cycle op: the CFU model returns src1|src2.
    drive(3'd1, 7'd0, 32'h0000_00F0, 32'h0000_000F, 5'd5);
    cfu_stall_i = 1'b0;
    cfu_rslt_i  = src1_i | src2_i;
    sb.push_back('{5'd5, 32'h0000_00FF});
    tick(1, 0, 0, 0);
    chk_ops(3'd1, 7'd0, 32'h0000_00F0, 32'h0000_000F);
    tick(1, 1, 0, 0);
    valid_i = 1'b0;
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    chk("single_wb_cnt", 32'(wb_cnt), 32'd1);
    chk("wb_data_hold",  wb_data_o,   32'h0000_00FF);

    // Multi-cycle op: 4 stall cycles after enable, writeback at cycle 6.
    drive(3'd3, 7'h21, 32'hA5A5_0001, 32'h5A5A_0002, 5'd9);
    cfu_stall_i = 1'b1;
    sb.push_back('{5'd9, 32'h1234_5678});
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      chk_ops(3'd3, 7'h21, 32'hA5A5_0001, 32'h5A5A_0002);
      tick(1, 1, 0, 0);
    end
    cfu_stall_i = 1'b0;
    cfu_rslt_i  = 32'h1234_5678;
    chk_ops(3'd3, 7'h21, 32'hA5A5_0001, 32'h5A5A_0002);
    tick(1, 1, 0, 0);
    valid_i = 1'b0;
    tick(0, 0, 1, 0);
    chk("multi_wb_cnt", 32'(wb_cnt), 32'd2);

    // Flush in WAIT while the CFU is busy: DRAIN, then IDLE without writeback.
    drive(3'd2, 7'h05, 32'h0BAD_0001, 32'h0BAD_0002, 5'd3);
    cfu_stall_i = 1'b1;
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    flush_i = 1'b1;
    tick(1, 1, 0, 0);
    flush_i = 1'b0; valid_i = 1'b0;
    tick(1, 1, 0, 0);
    chk_ops(3'd2, 7'h05, 32'h0BAD_0001, 32'h0BAD_0002);
    tick(1, 1, 0, 0);
    cfu_stall_i = 1'b0;
    cfu_rslt_i  = 32'hDEAD_BEEF;
    tick(1, 1, 0, 0);
    tick(0, 0, 0, 0);
    chk("flush_data_hold", wb_data_o,    32'h1234_5678);
    chk("flush_rd_hold",   32'(wb_rd_o), 32'd9);

    // Flush in IDLE: nothing is accepted.
    drive(3'd0, 7'd0, 32'h1, 32'h2, 5'd4);
    flush_i = 1'b1;
    tick(0, 0, 0, 0);
    flush_i = 1'b0; valid_i = 1'b0;
    tick(0, 0, 0, 0);

    // Flush in ISSUE with the result ready: straight back to IDLE, no writeback.
    drive(3'd0, 7'd0, 32'h11, 32'h22, 5'd4);
    cfu_stall_i = 1'b0;
    cfu_rslt_i  = 32'h33;
    tick(1, 0, 0, 0);
    flush_i = 1'b1;
    tick(1, 1, 0, 0);
    flush_i = 1'b0; valid_i = 1'b0;
    tick(0, 0, 0, 0);
    chk("flush_issue_wb_cnt", 32'(wb_cnt), 32'd2);

    // Back-to-back, rd=0 then rd=7; the second is presented during DONE.
    drive(3'd0, 7'd0, 32'h1, 32'h2, 5'd0);
    cfu_rslt_i = 32'h3;
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    drive(3'd4, 7'h11, 32'h10, 32'h20, 5'd7);
    cfu_rslt_i = 32'h30;
    sb.push_back('{5'd7, 32'h30});
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk_ops(3'd4, 7'h11, 32'h10, 32'h20);
    tick(1, 1, 0, 0);
    valid_i = 1'b0;
    tick(0, 0, 1, 0);
    chk("b2b_wb_cnt", 32'(wb_cnt), 32'd3);

    // Stuck CFU: aborts after 8 WAIT cycles when the timeout is built,
    // otherwise the controller simply keeps waiting.
    drive(3'd5, 7'h02, 32'hCAFE_0000, 32'h0000_F00D, 5'd11);
    cfu_stall_i = 1'b1;
`ifdef CFU_TIMEOUT_EN
    sb.push_back('{5'd11, 32'hFFFF_FFFF});
    tick(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick(1, 1, 0, 0);
    valid_i = 1'b0;
    tick(0, 0, 1, 1);
    cfu_stall_i = 1'b0;
    tick(0, 0, 0, 0);
`else
    tick(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) tick(1, 1, 0, 0);
    cfu_stall_i = 1'b0;
    cfu_rslt_i  = src1_i | src2_i;
    sb.push_back('{5'd11, 32'hCAFE_F00D});
    tick(1, 1, 0, 0);
    valid_i = 1'b0;
    tick(0, 0, 1, 0);
`endif
    chk("stuck_wb_cnt", 32'(wb_cnt), 32'd4);

    // Asynchronous reset mid-WAIT, then a clean accept.
    drive(3'd6, 7'h7F, 32'h5555_5555, 32'hAAAA_AAAA, 5'd13);
    cfu_stall_i = 1'b1;
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_cfu_en",   32'(cfu_en_o),   32'd0);
    chk("arst_stall",    32'(stall_o),    32'd0);
    chk("arst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("arst_err",      32'(err_o),      32'd0);
    chk("arst_wb_data",  wb_data_o,       32'd0);
    chk("arst_wb_rd",    32'(wb_rd_o),    32'd0);
    chk_ops(3'd0, 7'd0, 32'd0, 32'd0);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    drive(3'd1, 7'h01, 32'h0000_0070, 32'h0000_0007, 5'd13);
    cfu_stall_i = 1'b0;
    cfu_rslt_i  = src1_i | src2_i;
    sb.push_back('{5'd13, 32'h0000_0077});
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    valid_i = 1'b0;
    tick(0, 0, 1, 0);
    chk("post_rst_wb_cnt", 32'(wb_cnt), 32'd5);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
